// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the data-side load/store sequencer: funct3 encodings,
// sequencer state type and the request legality check.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_B  = 3'd0;
    localparam logic [2:0] LSU_H  = 3'd1;
    localparam logic [2:0] LSU_W  = 3'd2;
    localparam logic [2:0] LSU_BU = 3'd4;
    localparam logic [2:0] LSU_HU = 3'd5;

    typedef enum logic {
        IDLE,
        READ
    } lsu_state_t;

    // True when funct3 is not a legal access of this kind or the offset breaks its alignment.
    function automatic logic lsu_fault(input logic is_store, input logic [2:0] funct,
                                       input logic [1:0] offset);
        logic bad_funct;
        logic misaligned;
        if (is_store) bad_funct = (funct > LSU_W);
        else          bad_funct = !(funct inside {LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU});
        case (funct)
            LSU_H, LSU_HU: misaligned = offset[0];
            LSU_W:         misaligned = (offset != 2'b00);
            default:       misaligned = 1'b0;
        endcase
        return bad_funct || misaligned;
    endfunction

endpackage

// File: rtl/load_store_unit_load_extract.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends
// it according to the load funct3.
module load_extract
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_Word,
    input  logic [1:0]  i_Offset,
    input  logic [2:0]  i_Funct,
    output logic [31:0] o_Result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = i_Word[{i_Offset, 3'b000} +: 8];
        half_sel = i_Word[{i_Offset[1], 4'b0000} +: 16];
        case (i_Funct)
            LSU_B:   o_Result = {{24{byte_sel[7]}}, byte_sel};
            LSU_H:   o_Result = {{16{half_sel[15]}}, half_sel};
            LSU_W:   o_Result = i_Word;
            LSU_BU:  o_Result = {24'd0, byte_sel};
            LSU_HU:  o_Result = {16'd0, half_sel};
            default: o_Result = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data memory sequencer for RV32I loads/stores on a word memory without byte
// enables: sub-word stores are read-modify-write, loads take one read cycle.
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic [2:0]  i_Funct,
    input  logic [31:0] i_Address,
    input  logic [31:0] i_StoreData,
    output logic        o_Stall,
    output logic        o_LoadValid,
    output logic [31:0] o_LoadData,
    output logic        o_Fault,
    output logic [31:0] o_MemAddress,
    output logic        o_MemReadEnable,
    output logic        o_MemWriteEnable,
    output logic [31:0] o_MemDataOut,
    input  logic [31:0] i_MemDataIn
);

    lsu_state_t  state_q, state_d;
    logic [2:0]  funct_q, funct_d;
    logic [1:0]  offset_q, offset_d;
    logic [31:0] store_data_q, store_data_d;
    logic        is_store_q, is_store_d;

    logic [31:0] extracted;
    logic [31:0] merged;

    load_extract u_load_extract (
        .i_Word   (i_MemDataIn),
        .i_Offset (offset_q),
        .i_Funct  (funct_q),
        .o_Result (extracted)
    );

    always_comb begin
        state_d          = state_q;
        funct_d          = funct_q;
        offset_d         = offset_q;
        store_data_d     = store_data_q;
        is_store_d       = is_store_q;
        o_Stall          = 1'b0;
        o_LoadValid      = 1'b0;
        o_LoadData       = '0;
        o_Fault          = 1'b0;
        o_MemReadEnable  = 1'b0;
        o_MemWriteEnable = 1'b0;
        o_MemDataOut     = '0;
        o_MemAddress     = i_Reset ? '0 : {i_Address[31:2], 2'b00};

        // Sub-word store merge; only SB/SH ever reach READ as stores, so anything not B is H.
        merged = i_MemDataIn;
        if (funct_q == LSU_B) merged[{offset_q, 3'b000} +: 8]     = store_data_q[7:0];
        else                  merged[{offset_q[1], 4'b0000} +: 16] = store_data_q[15:0];

        if (i_Reset) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_MemRead || i_MemWrite) begin
                        if (lsu_fault(i_MemWrite, i_Funct, i_Address[1:0])) begin
                            o_Fault = 1'b1;
                        end else if (i_MemWrite && (i_Funct == LSU_W)) begin
                            o_MemWriteEnable = 1'b1;
                            o_MemDataOut     = i_StoreData;
                        end else begin
                            o_MemReadEnable = 1'b1;
                            o_Stall         = 1'b1;
                            funct_d         = i_Funct;
                            offset_d        = i_Address[1:0];
                            store_data_d    = i_StoreData;
                            is_store_d      = i_MemWrite;
                            state_d         = READ;
                        end
                    end
                end
                READ: begin
                    if (is_store_q) begin
                        o_MemWriteEnable = 1'b1;
                        o_MemDataOut     = merged;
                    end else begin
                        o_LoadValid = 1'b1;
                        o_LoadData  = extracted;
                    end
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q      <= IDLE;
            funct_q      <= '0;
            offset_q     <= '0;
            store_data_q <= '0;
            is_store_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            funct_q      <= funct_d;
            offset_q     <= offset_d;
            store_data_q <= store_data_d;
            is_store_q   <= is_store_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues directed and random
// accesses, a monitor checks every load/write/fault against a reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        i_Reset;
    logic        i_MemRead;
    logic        i_MemWrite;
    logic [2:0]  i_Funct;
    logic [31:0] i_Address;
    logic [31:0] i_StoreData;
    logic        o_Stall;
    logic        o_LoadValid;
    logic [31:0] o_LoadData;
    logic        o_Fault;
    logic [31:0] o_MemAddress;
    logic        o_MemReadEnable;
    logic        o_MemWriteEnable;
    logic [31:0] o_MemDataOut;
    logic [31:0] i_MemDataIn;

    always #5 clk = ~clk;

    load_store_unit dut (
        .i_Clock          (clk),
        .i_Reset          (i_Reset),
        .i_MemRead        (i_MemRead),
        .i_MemWrite       (i_MemWrite),
        .i_Funct          (i_Funct),
        .i_Address        (i_Address),
        .i_StoreData      (i_StoreData),
        .o_Stall          (o_Stall),
        .o_LoadValid      (o_LoadValid),
        .o_LoadData       (o_LoadData),
        .o_Fault          (o_Fault),
        .o_MemAddress     (o_MemAddress),
        .o_MemReadEnable  (o_MemReadEnable),
        .o_MemWriteEnable (o_MemWriteEnable),
        .o_MemDataOut     (o_MemDataOut),
        .i_MemDataIn      (i_MemDataIn)
    );

    // Word memory with one-cycle synchronous read, as the DUT sees it.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (o_MemReadEnable)  i_MemDataIn <= mem[o_MemAddress[9:2]];
        if (o_MemWriteEnable) mem[o_MemAddress[9:2]] <= o_MemDataOut;
    end

    // Reference memory image, updated at issue time from the ISA rules.
    logic [31:0] ref_mem [256];

    typedef enum int { EXP_LOAD, EXP_WRITE, EXP_FAULT } exp_kind_t;
    typedef struct {
        exp_kind_t   kind;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    int ncheck = 0;
    int nfail  = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncheck++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f, input logic [31:0] addr);
        logic [31:0] word;
        int          a, b, h;
        word = ref_mem[addr[9:2]];
        a = int'(addr[1:0]);
        b = int'((word / (32'd1 << (8 * a))) % 256);
        h = int'((word / (32'd1 << (8 * a))) % 65536);
        case (f)
            3'd0:    return 32'(b >= 128 ? b - 256 : b);
            3'd1:    return 32'(h >= 32768 ? h - 65536 : h);
            3'd2:    return word;
            3'd4:    return 32'(b);
            3'd5:    return 32'(h);
            default: return 32'hX;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] f, input logic [31:0] addr,
                                              input logic [31:0] sd);
        logic [31:0] word, lanes, mask;
        int          a;
        word  = ref_mem[addr[9:2]];
        a     = int'(addr[1:0]);
        lanes = (f == 3'd0) ? 32'hFF : (f == 3'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask  = lanes << (8 * a);
        return (word & ~mask) | ((sd << (8 * a)) & mask);
    endfunction

    function automatic bit is_fault(input bit wr, input logic [2:0] f, input logic [31:0] addr);
        bit legal, aligned;
        if (wr) legal = (f <= 3'd2);
        else    legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd5);
        if (f == 3'd1 || f == 3'd5) aligned = (addr % 2 == 0);
        else if (f == 3'd2)         aligned = (addr % 4 == 0);
        else                        aligned = 1'b1;
        return !(legal && aligned);
    endfunction

    // Drive one instruction at posedge+1, check its per-cycle handshake, and queue its result.
    task automatic issue(input bit rd, input bit wr, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] sd);
        exp_t e;
        bit   flt, two_cycle, sw;
        flt       = is_fault(wr, f, addr);
        sw        = !flt && wr && (f == 3'd2);
        two_cycle = !flt && !sw;
        e.addr    = addr & 32'hFFFF_FFFC;
        if (flt) begin
            e.kind = EXP_FAULT; e.data = 32'd0;
        end else if (rd) begin
            e.kind = EXP_LOAD;  e.data = ref_load(f, addr);
        end else begin
            e.kind = EXP_WRITE; e.data = ref_store(f, addr, sd);
            ref_mem[addr[9:2]] = e.data;
        end
        sb.push_back(e);

        i_MemRead = rd; i_MemWrite = wr; i_Funct = f; i_Address = addr; i_StoreData = sd;
        #1;
        chk("c1_stall", 32'(o_Stall), 32'(two_cycle));
        chk("c1_read_en", 32'(o_MemReadEnable), 32'(two_cycle));
        chk("c1_write_en", 32'(o_MemWriteEnable), 32'(sw));
        chk("c1_mem_addr", o_MemAddress, addr & 32'hFFFF_FFFC);
        if (two_cycle) begin
            @(posedge clk); #1;
            chk("c2_stall", 32'(o_Stall), 32'd0);
            chk("c2_read_en", 32'(o_MemReadEnable), 32'd0);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        i_MemRead = 1'b0; i_MemWrite = 1'b0; i_Funct = 3'd0; i_Address = 32'd0; i_StoreData = 32'd0;
    endtask

    // Monitor: every DUT result event must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (o_LoadValid || o_MemWriteEnable || o_Fault) begin
            if (sb.size() == 0) begin
                ncheck++; nfail++;
                $display("FAIL unexpected_output: lv=%0b we=%0b fault=%0b with empty scoreboard at %0t",
                         o_LoadValid, o_MemWriteEnable, o_Fault, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                case (e.kind)
                    EXP_LOAD: begin
                        chk("load_valid", 32'(o_LoadValid), 32'd1);
                        chk("load_data", o_LoadData, e.data);
                    end
                    EXP_WRITE: begin
                        chk("write_en", 32'(o_MemWriteEnable), 32'd1);
                        chk("write_addr", o_MemAddress, e.addr);
                        chk("write_data", o_MemDataOut, e.data);
                    end
                    default: begin
                        chk("fault", 32'(o_Fault), 32'd1);
                        chk("fault_strobes", {30'd0, o_MemReadEnable, o_MemWriteEnable}, 32'd0);
                        chk("fault_stall", 32'(o_Stall), 32'd0);
                    end
                endcase
            end
        end else if (o_LoadData !== 32'd0) begin
            chk("load_data_idle", o_LoadData, 32'd0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] legal_f [5];
        logic [2:0] f;
        logic [31:0] addr, sd, hold;
        bit rd;
        legal_f[0] = 3'd0; legal_f[1] = 3'd1; legal_f[2] = 3'd2; legal_f[3] = 3'd4; legal_f[4] = 3'd5;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[8'h40]     = 32'h8899AABB;
        ref_mem[8'h40] = 32'h8899AABB;

        // Reset with a request present: every output must stay low.
        i_Reset = 1'b1;
        i_MemRead = 1'b1; i_MemWrite = 1'b0; i_Funct = 3'd0; i_Address = 32'h101; i_StoreData = 32'd0;
        @(posedge clk); #1;
        chk("reset_stall", 32'(o_Stall), 32'd0);
        chk("reset_strobes", {30'd0, o_MemReadEnable, o_MemWriteEnable}, 32'd0);
        chk("reset_addr", o_MemAddress, 32'd0);
        chk("reset_flags", {30'd0, o_LoadValid, o_Fault}, 32'd0);
        @(posedge clk); #1;
        i_Reset = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        chk("idle_outputs", {o_Stall, o_LoadValid, o_Fault, o_MemReadEnable, o_MemWriteEnable}, 32'd0);

        issue(1, 0, 3'd0, 32'h101, 32'd0);          // LB   -> FFFFFFAA
        issue(1, 0, 3'd5, 32'h102, 32'd0);          // LHU  -> 00008899
        issue(1, 0, 3'd1, 32'h102, 32'd0);          // LH   -> FFFF8899

        // SH 0x100 aborted by reset in its READ cycle.
        sd = 32'h0000_5A5A;
        i_MemRead = 0; i_MemWrite = 1; i_Funct = 3'd1; i_Address = 32'h100; i_StoreData = sd;
        #1;
        chk("rmw_abort_c1_stall", 32'(o_Stall), 32'd1);
        @(posedge clk); #1;
        i_Reset = 1'b1;
        #1;
        chk("rmw_abort_strobes", {30'd0, o_MemReadEnable, o_MemWriteEnable}, 32'd0);
        chk("rmw_abort_stall", 32'(o_Stall), 32'd0);
        @(posedge clk); #1;
        i_Reset = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        chk("rmw_abort_mem", mem[8'h40], 32'h8899AABB);
        issue(1, 0, 3'd0, 32'h100, 32'd0);          // LB 0x100 -> FFFFFFBB

        issue(0, 1, 3'd0, 32'h103, 32'h12345677);   // SB -> 7799AABB
        issue(0, 1, 3'd2, 32'h104, 32'hDEADBEEF);   // SW
        issue(1, 0, 3'd2, 32'h104, 32'd0);          // LW readback
        hold = mem[8'h40];
        issue(1, 0, 3'd2, 32'h102, 32'd0);          // misaligned LW
        issue(0, 1, 3'd1, 32'h101, 32'hFFFF);       // misaligned SH
        issue(1, 0, 3'd3, 32'h100, 32'd0);          // illegal funct
        issue(0, 1, 3'd4, 32'h100, 32'hFFFF);       // illegal store funct
        idle_inputs();
        @(posedge clk); #1;
        chk("sb_result", mem[8'h40], 32'h7799AABB);
        chk("fault_mem_unchanged", mem[8'h40], hold);

        for (int n = 0; n < 400; n++) begin
            rd   = $urandom_range(0, 1) == 1;
            addr = 32'h100 + $urandom_range(0, 63);
            if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
            else if (rd)                    f = legal_f[$urandom_range(0, 4)];
            else                            f = 3'($urandom_range(0, 2));
            // Mostly aligned so the memory-touching paths dominate.
            if ($urandom_range(0, 3) != 0) begin
                if (f == 3'd2) addr = addr & 32'hFFFF_FFFC;
                else if (f == 3'd1 || f == 3'd5) addr = addr & 32'hFFFF_FFFE;
            end
            issue(rd, !rd, f, addr, $urandom);
            if ($urandom_range(0, 4) == 0) begin
                idle_inputs();
                @(posedge clk); #1;
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        for (int w = 8'h40; w < 8'h50; w++) chk("final_mem", mem[w], ref_mem[w]);

        $display("[TB] %0d tests run, %0d failed", ncheck, nfail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-side memory sequencer between the execute stage (ALU address output, decoded funct/read/write controls, rs2 value) and the word-wide `memory` instance used as data memory. Implements RV32I LB/LH/LW/LBU/LHU/SB/SH/SW on a memory that has no byte enables and one-cycle synchronous read latency. Sub-word stores use a read-modify-write sequence. The block stalls the program counter while an access is in flight.

## Interface
Parameters:
- none. Widths are fixed at RV32.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- `i_Clock`  in  1  core clock.
- `i_Reset`  in  1  synchronous, active-high.
- `i_MemRead`  in  1  decoded load request.
- `i_MemWrite`  in  1  decoded store request. Never asserted together with `i_MemRead`.
- `i_Funct`  in  3  funct3 of the load/store.
- `i_Address`  in  32  byte address (ALU output).
- `i_StoreData`  in  32  rs2 value.
- `o_Stall`  out  1  hold PC and all request inputs this cycle.
- `o_LoadValid`  out  1  `o_LoadData` is the writeback value this cycle.
- `o_LoadData`  out  32  extended load result. 0 when `o_LoadValid`=0.
- `o_Fault`  out  1  misaligned address or illegal funct. One cycle, no memory access.
- `o_MemAddress`  out  32  `{i_Address[31:2],2'b00}`.
- `o_MemReadEnable`  out  1  memory read strobe.
- `o_MemWriteEnable`  out  1  memory write strobe.
- `o_MemDataOut`  out  32  word to write.
- `i_MemDataIn`  in  32  read word. Valid the cycle after `o_MemReadEnable`.

## Operation
- Little-endian. Byte offset is `a = i_Address[1:0]`.
- Legal funct values:
  - Loads: 0=B, 1=H, 2=W, 4=BU, 5=HU.
  - Stores: 0=B, 1=H, 2=W.
  - Any other value is illegal and raises `o_Fault`.
- Alignment rules:
  - H/HU/SH require `a[0]=0`.
  - W/SW require `a=0`.
  - A violation raises `o_Fault`.
- States: IDLE, READ.
- IDLE, neither request: all outputs 0.
- IDLE, fault:
  - `o_Fault`=1, `o_Stall`=0, all memory strobes 0.
  - Stay in IDLE.
- IDLE, legal SW:
  - `o_MemWriteEnable`=1, `o_MemDataOut`=`i_StoreData`, `o_Stall`=0.
  - Stay in IDLE.
- IDLE, legal load, SB or SH:
  - `o_MemReadEnable`=1, `o_Stall`=1.
  - Capture funct, offset and store data into registers; go to READ.
- READ, load:
  - Extract byte `a` or halfword `a[1]` from `i_MemDataIn`.
  - Sign-extend for B/H, zero-extend for BU/HU; W passes the word through.
  - `o_LoadValid`=1, `o_Stall`=0; go to IDLE.
- READ, SB/SH:
  - Replace byte `a` (or halfword `a[1]`) of `i_MemDataIn` with the low 8 (or 16) bits of the captured store data.
  - `o_MemWriteEnable`=1, `o_MemDataOut`=merged word, `o_Stall`=0; go to IDLE.
- READ uses the captured registers, not the live inputs. The inputs are still required stable while `o_Stall`=1.
- Handshake: the CPU holds `i_*` stable while `o_Stall`=1. The cycle after `o_Stall`=0 carries the next instruction. A back-to-back access is accepted immediately in IDLE.

## Timing
- While `i_Reset`=1:
  - State forced to IDLE.
  - All outputs 0, including strobes. Reset overrides any in-flight access.
- Reset during READ of SB/SH: the write is not issued and memory is unchanged.
- Latency:
  - SW and faults: 1 cycle, no stall.
  - All loads, SB and SH: 2 cycles, `o_Stall` high in cycle 1 only.
- `o_MemAddress` is combinational from `i_Address` in both states.
- No state beyond the captured registers and the 1-bit state.

## Structure
- Add to `cpudefs.sv`:
  - `LSU_B`=0, `LSU_H`=1, `LSU_W`=2, `LSU_BU`=4, `LSU_HU`=5.
  - The `lsu_state_t` enum {IDLE, READ}.
- Sub-module `load_extract` (combinational): inputs word, offset, funct; output is the extended result. Instantiated once.
- Store merge is inline.
- Target size: about 180 lines total.

## Test plan
Memory word at 0x100 is preloaded with 0x8899AABB.
- LB 0x101:
  - Cycle 1: stall=1, read strobe, `o_MemAddress`=0x100.
  - Cycle 2: `o_LoadValid`=1, `o_LoadData`=0xFFFFFFAA, stall=0.
- LHU 0x102 → `o_LoadData`=0x00008899. LH 0x102 → 0xFFFF8899.
- SB 0x103 with data 0x12345677 → read, then write. Word becomes 0x7799AABB; exactly one write strobe.
- SW 0x104 with 0xDEADBEEF → single cycle, no read strobe, stall=0. Readback LW 0x104 returns 0xDEADBEEF.
- LW 0x102, SH 0x101, and load funct=3 → `o_Fault`=1 for one cycle, both strobes 0, stall=0, memory unchanged.
- SH 0x100 with reset asserted in the READ cycle → no write strobe, state IDLE, word still 0x8899AABB. A following LB 0x100 returns 0xFFFFFFBB.
